gpr_file_param: RTL
===================

Name: gpr_file_param

Overview:
- Parametrised next-generation general-purpose register file for the bus-based datapath.
- Width and depth are generic. R0 is optionally hardwired to zero.
- Bus transfers use the existing GPR_select operand encoding. Bus output is registered, with an explicit drive flag instead of an internal tri-state.
- A handshaked dump sequencer streams every register out for debug/trace without stalling bus traffic.

Parameters:
- DATA_W, 16, register and bus width in bits.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, when 1, R0 ignores writes and always reads 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  data from shared bus, latched on write.
- bus_out  out  DATA_W  registered read data to bus.
- bus_drive  out  1  high while bus_out is valid; top level uses it as tri-state enable.
- gpr_in  in  1  write strobe (bus -> register).
- gpr_out  in  1  read strobe (register -> bus).
- gpr_select  in  3  operand source select.
- rd_1, rd_2, rs_1, rs_2  in  ADDR_W each  instruction register fields.
- sel_conflict  out  1  one-cycle pulse: gpr_in and gpr_out were both high.
- reg_flat  out  NUM_REGS*DATA_W  debug view; Ri at [i*DATA_W +: DATA_W].
- dump_start  in  1  request a full register dump.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts dump word.
- dump_addr  out  ADDR_W  index of the current dump word.
- dump_data  out  DATA_W  current dump word.
- dump_busy  out  1  sequencer not idle.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset is synchronous; it overrides all other inputs that cycle.
  - All registers, bus_out, bus_drive, sel_conflict, dump_valid, dump_addr, dump_data, dump_busy and dump_done go to 0.
  - Dump FSM goes to IDLE.
- Select decode (combinational) to sel_addr:
  - 000 -> 0; 001 -> NUM_REGS-1; 010 -> rd_1; 011 -> rd_2; 100 -> rs_1; 101 -> rs_2.
  - 110 and 111 are invalid: a write is discarded, a read returns 0 (bus_drive still asserts).
- Write (gpr_in=1, gpr_out=0): at the edge, R[sel_addr] <= bus_in.
  - Discarded if sel_addr==0 and ZERO_REG=1.
  - New value is visible on reg_flat the next cycle.
- Read (gpr_out=1, gpr_in=0): 1-cycle latency.
  - At edge N, bus_out <= R[sel_addr] and bus_drive <= 1; valid during cycle N+1.
  - Back-to-back reads give one word per cycle.
- No strobe: at the edge, bus_drive <= 0 and bus_out <= 0.
- Both strobes high: no write, bus_drive <= 0, bus_out <= 0, sel_conflict <= 1 for exactly one cycle per offending cycle.
- R0 with ZERO_REG=1 reads 0 on every path: bus, dump and reg_flat.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start=1 -> capture R[0] into dump_data, dump_addr <= 0, dump_valid <= 1, go to SEND. dump_busy=1 in SEND and DONE.
  - SEND: dump_valid=1.
    - dump_ready=0: dump_addr and dump_data hold stable.
    - dump_ready=1 and dump_addr < NUM_REGS-1: dump_addr increments and the next register is captured. Throughput is one word per cycle.
    - dump_ready=1 and dump_addr == NUM_REGS-1: dump_valid <= 0, go to DONE.
  - DONE: dump_done=1 for one cycle, then IDLE.
  - dump_start outside IDLE is ignored (no queueing).
- Write/dump same-edge bypass: if a bus write targets the register being captured at that edge, dump_data takes the new bus_in value (write-first).
- Words already presented and held under backpressure are not updated by later writes.
- Bus reads/writes proceed concurrently with a dump at full rate.
- Reset mid-dump: immediate return to IDLE; no dump_done pulse.

Decomposition:
- Shared package gpr_pkg holds:
  - GPR_SEL_* localparams for the 3-bit select encoding.
  - Dump FSM state enum (IDLE/SEND/DONE).
- Sub-module gpr_dump_seq: dump FSM, index counter and handshake.
  - Reads the register array through a read-address/read-data pair.
  - Receives write address/data/enable for the bypass.
- The top module holds the storage array, select decode and bus logic.

Test Plan:
- Reset, then write 16'hBEEF with gpr_select=010, rd_1=3 -> reg_flat R3=16'hBEEF next cycle. A read with gpr_select=010 -> bus_out=16'hBEEF, bus_drive=1 exactly one cycle after the strobe.
- Write 16'h1234 with gpr_select=000 (ZERO_REG=1), then read R0 -> bus_out=0. Write with gpr_select=001 -> R7=16'h1234. Read with gpr_select=110 -> bus_out=0 with bus_drive=1.
- gpr_in=gpr_out=1 with rs_1=2 holding 16'h00AA -> R2 unchanged, bus_drive=0, sel_conflict high for one cycle.
- Load Ri=16'h1000+i, pulse dump_start with dump_ready tied 1 -> 8 consecutive valid beats with addr 0..7 and data 0,1001..1007. dump_done pulses one cycle after the last beat; dump_busy=0 afterwards.
- Dump with dump_ready toggling 1,0,0,1 plus a write of 16'hCAFE to R4 on the same edge R4 is captured -> held beats stay stable and beat 4 carries 16'hCAFE.
- Assert reset while dump_addr=3 -> next cycle dump_valid=0, dump_busy=0, no dump_done, all registers read 0.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: operand select
// encoding and dump sequencer states.
package gpr_pkg;

    localparam logic [2:0] GPR_SEL_R0    = 3'b000;
    localparam logic [2:0] GPR_SEL_RLAST = 3'b001;
    localparam logic [2:0] GPR_SEL_RD1   = 3'b010;
    localparam logic [2:0] GPR_SEL_RD2   = 3'b011;
    localparam logic [2:0] GPR_SEL_RS1   = 3'b100;
    localparam logic [2:0] GPR_SEL_RS2   = 3'b101;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/gpr_dump_seq.sv
// Handshaked sequencer that streams every register out, one word per accepted
// beat, with write-first bypass of a same-edge bus write.
module gpr_dump_seq
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              capture;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (start_i) begin
                    state_d = DUMP_SEND;
                    addr_d  = '0;
                    capture = 1'b1;
                end
            end
            DUMP_SEND: begin
                if (ready_i) begin
                    if (addr_q == LAST) begin
                        state_d = DUMP_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        capture = 1'b1;
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    // The captured word is only refreshed on a capture, so a held beat never
    // picks up later writes.
    assign rd_addr_o = addr_d;
    assign data_d    = !capture ? data_q :
                       (wr_en_i && wr_addr_i == addr_d) ? wr_data_i : rd_data_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == DUMP_SEND);
    assign busy_o  = (state_q != DUMP_IDLE);
    assign done_o  = (state_q == DUMP_DONE);
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/gpr_file_param.sv
// Parametrised register file on a shared bus: select decode, registered bus
// read port with drive flag, and a concurrent debug dump port.
module gpr_file_param
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          bus_in,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       bus_drive,
    input  logic                       gpr_in,
    input  logic                       gpr_out,
    input  logic [2:0]                 gpr_select,
    input  logic [ADDR_W-1:0]          rd_1,
    input  logic [ADDR_W-1:0]          rd_2,
    input  logic [ADDR_W-1:0]          rs_1,
    input  logic [ADDR_W-1:0]          rs_2,
    output logic                       sel_conflict,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat,
    input  logic                       dump_start,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [ADDR_W-1:0]          dump_addr,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_busy,
    output logic                       dump_done
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [ADDR_W-1:0] sel_addr, dump_rd_addr;
    logic              sel_valid, wr_en, rd_en;
    logic [DATA_W-1:0] rd_word, bus_out_q, bus_out_d;
    logic              bus_drive_q, sel_conflict_q;

    always_comb begin
        sel_addr  = '0;
        sel_valid = 1'b1;
        case (gpr_select)
            GPR_SEL_R0:    sel_addr = '0;
            GPR_SEL_RLAST: sel_addr = '1;
            GPR_SEL_RD1:   sel_addr = rd_1;
            GPR_SEL_RD2:   sel_addr = rd_2;
            GPR_SEL_RS1:   sel_addr = rs_1;
            GPR_SEL_RS2:   sel_addr = rs_2;
            default:       sel_valid = 1'b0;
        endcase
    end

    // R0 is never written when hardwired, so every read path sees zero there.
    assign wr_en     = gpr_in && !gpr_out && sel_valid && !(ZERO_REG && sel_addr == '0);
    assign rd_en     = gpr_out && !gpr_in;
    assign rd_word   = sel_valid ? regs_q[sel_addr] : '0;
    assign bus_out_d = rd_en ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q         <= '0;
            bus_out_q      <= '0;
            bus_drive_q    <= 1'b0;
            sel_conflict_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[sel_addr] <= bus_in;
            bus_out_q      <= bus_out_d;
            bus_drive_q    <= rd_en;
            sel_conflict_q <= gpr_in && gpr_out;
        end
    end

    assign bus_out      = bus_out_q;
    assign bus_drive    = bus_drive_q;
    assign sel_conflict = sel_conflict_q;
    assign reg_flat     = regs_q;

    gpr_dump_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk       (clk),
        .reset     (reset),
        .start_i   (dump_start),
        .ready_i   (dump_ready),
        .rd_addr_o (dump_rd_addr),
        .rd_data_i (regs_q[dump_rd_addr]),
        .wr_en_i   (wr_en),
        .wr_addr_i (sel_addr),
        .wr_data_i (bus_in),
        .valid_o   (dump_valid),
        .addr_o    (dump_addr),
        .data_o    (dump_data),
        .busy_o    (dump_busy),
        .done_o    (dump_done)
    );

endmodule
